// File: rtl/hub75_panel_driver_if.sv
// hub75_panel_driver_if: host pixel-write bus into the HUB75 frame buffer
interface hub75_panel_driver_if #(parameter int NUM_PANELS = 4);
  logic ctrl_en;
  logic [NUM_PANELS-1:0] ctrl_wr;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  modport master (output ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat);
  modport slave (input ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat);
endinterface

// File: rtl/hub75_panel_driver.sv
// hub75_panel_driver: frame buffer plus BCM refresh engine for chained 64x64 1/32-scan HUB75 panels
module hub75_panel_driver #(
  parameter int PANEL_W    = 64,
  parameter int PANEL_H    = 64,
  parameter int NUM_PANELS = 4,
  parameter int BITDEPTH   = 8,
  parameter int OE_BASE    = 1
) (
  input  logic clk,
  input  logic reset,
  hub75_panel_driver_if.slave bus,
  output logic panel_r0,
  output logic panel_g0,
  output logic panel_b0,
  output logic panel_r1,
  output logic panel_g1,
  output logic panel_b1,
  output logic panel_a,
  output logic panel_b,
  output logic panel_c,
  output logic panel_d,
  output logic panel_e,
  output logic panel_clk,
  output logic panel_stb,
  output logic panel_oe
);
  localparam int N  = PANEL_W * NUM_PANELS;
  localparam int CW = $clog2(PANEL_W);
  localparam int RW = $clog2(PANEL_H / 2);
  localparam int GW = $clog2(N);
  localparam int BW = $clog2(BITDEPTH);
  localparam int DEPTH = PANEL_W * PANEL_H / 2;
  typedef enum logic [1:0] {PREFETCH, SHIFT, LATCH, DISPLAY} state_t;
  state_t state;
  logic [GW:0] cnt;
  logic [15:0] dcnt;
  logic [BW-1:0] plane;
  logic [RW-1:0] row;
  logic [RW-1:0] addr;
  logic [23:0] top_mem [NUM_PANELS][DEPTH];
  logic [23:0] bot_mem [NUM_PANELS][DEPTH];
  logic [23:0] rd_top [NUM_PANELS];
  logic [23:0] rd_bot [NUM_PANELS];
  logic [GW-CW-1:0] sel;
  logic [GW-1:0] g_rd;
  logic rd_en;
  logic shifting;
  logic [RW+CW-1:0] wr_idx;
  logic wr_bot;
  logic [BITDEPTH-1:0] tr, tg, tbl, br, bg, bbl;
  logic addr_unused;
  assign addr_unused = ^{bus.ctrl_addr[15:14], bus.ctrl_addr[7:6]};
  assign wr_idx = {bus.ctrl_addr[RW-1:0], bus.ctrl_addr[8 +: CW]};
  assign wr_bot = bus.ctrl_addr[RW];
  // Slot k shows global column N-1-k; the next slot's pixel is fetched on the high half of the current one
  assign g_rd = GW'(N - 1) - (state == PREFETCH ? '0 : GW'(cnt[GW:1] + 1));
  assign rd_en = state == PREFETCH || (state == SHIFT && cnt[0]);
  assign shifting = state == SHIFT;
  assign {tr, tg, tbl} = rd_top[sel];
  assign {br, bg, bbl} = rd_bot[sel];
  assign panel_r0 = shifting && tr[plane];
  assign panel_g0 = shifting && tg[plane];
  assign panel_b0 = shifting && tbl[plane];
  assign panel_r1 = shifting && br[plane];
  assign panel_g1 = shifting && bg[plane];
  assign panel_b1 = shifting && bbl[plane];
  assign {panel_e, panel_d, panel_c, panel_b, panel_a} = addr;
  // Per-block half-panel RAMs: broadcast host writes, one-cycle registered refresh reads
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PANELS; i++) begin
      if (bus.ctrl_en && bus.ctrl_wr[i] && wr_bot) bot_mem[i][wr_idx] <= bus.ctrl_wdat;
      if (bus.ctrl_en && bus.ctrl_wr[i] && !wr_bot) top_mem[i][wr_idx] <= bus.ctrl_wdat;
      if (rd_en) rd_top[i] <= top_mem[i][{row, g_rd[CW-1:0]}];
      if (rd_en) rd_bot[i] <= bot_mem[i][{row, g_rd[CW-1:0]}];
    end
    if (rd_en) sel <= g_rd[GW-1:CW];
  end
  // Refresh sequencer: prefetch, shift a row plane, latch it, then light it for a binary-weighted time
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PREFETCH;
      cnt <= '0;
      dcnt <= '0;
      plane <= '0;
      row <= '0;
      addr <= '0;
      panel_clk <= 1'b0;
      panel_stb <= 1'b0;
      panel_oe <= 1'b1;
    end else begin
      case (state)
        PREFETCH: begin
          state <= SHIFT;
          cnt <= '0;
        end
        SHIFT: begin
          if (cnt == (GW+1)'(2 * N - 1)) begin
            state <= LATCH;
            panel_clk <= 1'b0;
            panel_stb <= 1'b1;
            addr <= row;
          end else begin
            cnt <= cnt + (GW+1)'(1);
            panel_clk <= ~cnt[0];
          end
        end
        LATCH: begin
          state <= DISPLAY;
          panel_stb <= 1'b0;
          panel_oe <= 1'b0;
          dcnt <= 16'(OE_BASE << plane) - 16'd1;
        end
        default: begin
          if (dcnt == '0) begin
            state <= PREFETCH;
            panel_oe <= 1'b1;
            plane <= plane == BW'(BITDEPTH - 1) ? '0 : plane + BW'(1);
            if (plane == BW'(BITDEPTH - 1)) row <= row + RW'(1);
          end else begin
            dcnt <= dcnt - 16'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hub75_panel_driver.sv
// tb_hub75_panel_driver: random pixel writes, scoreboarded refresh planes against a frame-buffer model
module tb_hub75_panel_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  hub75_panel_driver_if bus();
  logic r0, g0, b0, r1, g1, b1, pa, pb, pc, pd, pe, pclk, stb, oe;
  hub75_panel_driver dut (
    .clk(clk), .reset(reset), .bus(bus),
    .panel_r0(r0), .panel_g0(g0), .panel_b0(b0),
    .panel_r1(r1), .panel_g1(g1), .panel_b1(b1),
    .panel_a(pa), .panel_b(pb), .panel_c(pc), .panel_d(pd), .panel_e(pe),
    .panel_clk(pclk), .panel_stb(stb), .panel_oe(oe)
  );
  typedef struct {int row; int b;} plane_t;
  plane_t exp_q[$];
  logic [23:0] fb [4][64][64];
  logic [5:0] cap[$];
  int tests = 0;
  int fails = 0;
  int planes_done = 0;
  int run = 0;
  int cur_b = -1;
  logic prev_clk = 1'b0;
  function automatic logic bitof(input logic [23:0] v, input int s);
    return 1'(v >> s);
  endfunction
  function automatic logic [5:0] exp_slot(input int row, input int b, input int k);
    int g;
    logic [23:0] t, u;
    g = 255 - k;
    t = fb[g / 64][row][g % 64];
    u = fb[g / 64][row + 32][g % 64];
    return {bitof(t, 16 + b), bitof(t, 8 + b), bitof(t, b), bitof(u, 16 + b), bitof(u, 8 + b), bitof(u, b)};
  endfunction
  // Monitor: capture each shift-clock rise, check each latched plane and its lit time
  always @(negedge clk) begin
    logic [5:0] d;
    plane_t e;
    int mism, first;
    d = {r0, g0, b0, r1, g1, b1};
    if (reset) begin
      cap.delete();
      run = 0;
      cur_b = -1;
      prev_clk = 1'b0;
    end else begin
      if (pclk || stb || !oe) begin
        tests++;
        if ((pclk && (stb || !oe)) || ((stb || !oe) && d != 0) || (stb && !oe)) begin
          fails++;
          $display("FAIL invariant clk=%0b stb=%0b oe=%0b data=%0h", pclk, stb, oe, d);
        end
      end
      if (pclk && !prev_clk) cap.push_back(d);
      if (stb) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL exp_empty unexpected latch, got row %0d", {pe, pd, pc, pb, pa});
        end else begin
          e = exp_q.pop_front();
          if (cap.size() != 256) begin
            fails++;
            $display("FAIL slot_count got %0d want 256 (row %0d plane %0d)", cap.size(), e.row, e.b);
          end
          tests++;
          if ({pe, pd, pc, pb, pa} != 5'(e.row)) begin
            fails++;
            $display("FAIL row_addr got %0d want %0d", {pe, pd, pc, pb, pa}, e.row);
          end
          mism = 0;
          first = -1;
          for (int k = 0; k < cap.size(); k++) begin
            if (cap[k] != exp_slot(e.row, e.b, k)) begin
              mism++;
              if (first < 0) first = k;
            end
          end
          tests++;
          if (mism != 0) begin
            fails++;
            $display("FAIL slot_data row %0d plane %0d: %0d bad slots, slot %0d got %b want %b",
                     e.row, e.b, mism, first, cap[first], exp_slot(e.row, e.b, first));
          end
          cur_b = e.b;
        end
        cap.delete();
      end
      if (!oe) run++;
      else if (run > 0) begin
        tests++;
        if (cur_b < 0 || run != (1 << cur_b)) begin
          fails++;
          $display("FAIL oe_len got %0d want %0d", run, cur_b < 0 ? -1 : (1 << cur_b));
        end
        planes_done++;
        run = 0;
      end
      prev_clk = pclk;
    end
  end
  task automatic wr(input logic en, input logic [3:0] m, input logic [15:0] a, input logic [23:0] d);
    @(posedge clk);
    #1;
    bus.ctrl_en = en;
    bus.ctrl_wr = m;
    bus.ctrl_addr = a;
    bus.ctrl_wdat = d;
    if (en) for (int i = 0; i < 4; i++) if (m[i]) fb[i][a[5:0]][a[13:8]] = d;
  endtask
  task automatic check_idle(input string tag);
    @(negedge clk);
    tests++;
    if ({oe, stb, pclk, pe, pd, pc, pb, pa, r0, g0, b0, r1, g1, b1} != 14'h2000) begin
      fails++;
      $display("FAIL %s got oe=%0b stb=%0b clk=%0b addr=%0d data=%b want oe=1 others 0",
               tag, oe, stb, pclk, {pe, pd, pc, pb, pa}, {r0, g0, b0, r1, g1, b1});
    end
  endtask
  task automatic release_check();
    int n;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!pclk && n < 10);
    tests++;
    if (n != 2) begin
      fails++;
      $display("FAIL first_rise got %0d clk want 2", n);
    end
  endtask
  task automatic wait_planes(input int target, input int budget);
    int n;
    n = 0;
    while (planes_done < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (planes_done < target) begin
      fails++;
      $display("FAIL plane_timeout got %0d planes want %0d", planes_done, target);
    end
  endtask
  initial begin
    int base, n, row;
    bus.ctrl_en = 1'b0;
    bus.ctrl_wr = '0;
    bus.ctrl_addr = '0;
    bus.ctrl_wdat = '0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        wr(1'b1, 4'hF, {2'b00, 6'(c), 2'b00, 6'(r)}, 24'h0);
    repeat (200) begin
      row = $urandom_range(0, 9) + ($urandom_range(0, 1) != 0 ? 32 : 0);
      wr($urandom_range(0, 7) != 0, 4'($urandom), {2'($urandom), 6'($urandom_range(0, 63)), 2'($urandom), 6'(row)}, 24'($urandom));
    end
    wr(1'b1, 4'b0001, {2'b00, 6'd0, 2'b00, 6'd0}, 24'hFF0000);
    wr(1'b1, 4'b1000, {2'b00, 6'd5, 2'b00, 6'd40}, 24'h000080);
    wr(1'b1, 4'b1111, {2'b11, 6'd63, 2'b10, 6'd0}, 24'h00FF00);
    wr(1'b0, 4'b1111, {2'b00, 6'd1, 2'b00, 6'd0}, 24'hFFFFFF);
    @(posedge clk);
    #1;
    bus.ctrl_en = 1'b0;
    repeat (8) @(posedge clk);
    check_idle("reset_hold");
    for (int r = 0; r < 9; r++) for (int b = 0; b < 8; b++) exp_q.push_back('{r, b});
    release_check();
    wait_planes(72, 72 * 700);
    repeat (200) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({pe, pd, pc, pb, pa} != 5'd8) begin
      fails++;
      $display("FAIL addr_before_reset got %0d want 8", {pe, pd, pc, pb, pa});
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    check_idle("reset_mid_shift");
    exp_q.delete();
    for (int b = 0; b < 8; b++) exp_q.push_back('{0, b});
    base = planes_done;
    release_check();
    wait_planes(base + 7, 7 * 700);
    n = 0;
    while (oe && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (oe) begin
      fails++;
      $display("FAIL display_timeout oe stayed %0b want 0", oe);
    end
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    check_idle("reset_mid_display");
    exp_q.delete();
    for (int b = 0; b < 8; b++) exp_q.push_back('{0, b});
    exp_q.push_back('{1, 0});
    base = planes_done;
    release_check();
    wait_planes(base + 9, 9 * 700);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
